// File: rtl/sync_up_counter_pkg.sv
// Shared constants for the synchronous up-counter family.
package counter_pkg;
  localparam int unsigned COUNT_MODE_WRAP   = 0;
  localparam int unsigned COUNT_MODE_SAT    = 1;
  localparam int unsigned DEFAULT_WIDTH     = 4;
  localparam int unsigned DEFAULT_MAX_COUNT = (1 << DEFAULT_WIDTH) - 1;
endpackage

// File: rtl/sync_up_counter_if.sv
// Control/status bundle between a counter stage and whatever drives it.
interface sync_up_counter_if #(
  parameter int unsigned WIDTH = counter_pkg::DEFAULT_WIDTH
);
  logic             en;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             wrap;
  logic             ovf;

  modport master (output en, clr, load, load_val, input out, tc, wrap, ovf);
  modport slave  (input en, clr, load, load_val, output out, tc, wrap, ovf);
endinterface

// File: rtl/up_count_bit.sv
// One counter bit: D flip-flop with clear > load > toggle next-state mux.
module up_count_bit (
  input  logic clk,
  input  logic rst,
  input  logic toggle_in,
  input  logic clr,
  input  logic load,
  input  logic load_bit,
  output logic q
);
  logic d;

  always_comb begin
    d = q;
    if (clr)            d = 1'b0;
    else if (load)      d = load_bit;
    else if (toggle_in) d = ~q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= 1'b0;
    else      q <= d;
  end
endmodule

// File: rtl/sync_up_counter.sv
// Up-counter built from per-bit toggle slices, with terminal detect,
// load clamping, wrap/saturate handling and a sticky overflow flag.
module sync_up_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = DEFAULT_MAX_COUNT,
  parameter int unsigned SATURATE  = COUNT_MODE_WRAP
) (
  input  logic              clk,
  input  logic              rst,
  sync_up_counter_if.slave  cnt
);
  localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_COUNT);
  localparam logic             SAT_MODE = (SATURATE == COUNT_MODE_SAT);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] carry;
  logic             at_max;
  logic             hit_max;
  logic             roll;
  logic             slice_clr;
  logic             wrap_q;
  logic             ovf_q;

  // Terminal rollover reuses the slices' clear path, so MAX_COUNT need not
  // be all-ones; the carry chain is blocked at MAX so saturate simply holds.
  always_comb begin
    at_max       = (q == MAX_V);
    hit_max      = cnt.en & at_max & ~cnt.load & ~cnt.clr;
    roll         = hit_max & ~SAT_MODE;
    slice_clr    = cnt.clr | roll;
    load_clamped = (cnt.load_val > MAX_V) ? MAX_V : cnt.load_val;
    carry        = '0;
    carry[0]     = cnt.en & ~at_max;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      carry[i] = carry[i-1] & q[i-1];
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    up_count_bit u_bit (
      .clk       (clk),
      .rst       (rst),
      .toggle_in (carry[g]),
      .clr       (slice_clr),
      .load      (cnt.load),
      .load_bit  (load_clamped[g]),
      .q         (q[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (cnt.clr) begin
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      wrap_q <= roll;
      if (hit_max) ovf_q <= 1'b1;
    end
  end

  assign cnt.out  = q;
  assign cnt.tc   = at_max & cnt.en;
  assign cnt.wrap = wrap_q;
  assign cnt.ovf  = ovf_q;
endmodule

// File: tb/tb_sync_up_counter.sv
// Bench for sync_up_counter: vector table, directed corner sequences and
// randomized traffic against an arithmetic reference model.
module tb_sync_up_counter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sync_up_counter_if #(.WIDTH(4)) if0 ();
  sync_up_counter_if #(.WIDTH(4)) if9 ();
  sync_up_counter_if #(.WIDTH(4)) ifs ();
  sync_up_counter_if #(.WIDTH(4)) ifc0 ();
  sync_up_counter_if #(.WIDTH(4)) ifc1 ();

  sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) dut0 (.clk(clk), .rst(rst), .cnt(if0));
  sync_up_counter #(.WIDTH(4), .MAX_COUNT(9),  .SATURATE(0)) dut9 (.clk(clk), .rst(rst), .cnt(if9));
  sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(1)) duts (.clk(clk), .rst(rst), .cnt(ifs));
  sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) dutc0 (.clk(clk), .rst(rst), .cnt(ifc0));
  sync_up_counter #(.WIDTH(4), .MAX_COUNT(15), .SATURATE(0)) dutc1 (.clk(clk), .rst(rst), .cnt(ifc1));

  assign ifc1.en       = ifc0.tc;
  assign ifc1.load     = 1'b0;
  assign ifc1.load_val = 4'd0;

  typedef struct {
    logic       en;
    logic       clr;
    logic       load;
    logic [3:0] lv;
    int         e_out;
    int         e_wrap;
    int         e_ovf;
  } vec_t;

  vec_t tbl[14];

  int maxv[3] = '{15, 9, 15};
  int satv[3] = '{0, 0, 1};
  int m_out[3];
  int m_ovf[3];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic en, input logic clr, input logic load, input logic [3:0] lv);
    if0.en = en; if0.clr = clr; if0.load = load; if0.load_val = lv;
  endtask
  task automatic set9(input logic en, input logic clr, input logic load, input logic [3:0] lv);
    if9.en = en; if9.clr = clr; if9.load = load; if9.load_val = lv;
  endtask
  task automatic sets(input logic en, input logic clr, input logic load, input logic [3:0] lv);
    ifs.en = en; ifs.clr = clr; ifs.load = load; ifs.load_val = lv;
  endtask

  // Reference: next state from the counting rules, modulo MAX+1 arithmetic.
  task automatic model_step(input int out, input int ovf, input int en, input int clr,
                            input int load, input int lv, input int mx, input int sat,
                            output int n_out, output int n_wrap, output int n_ovf);
    n_out = out; n_wrap = 0; n_ovf = ovf;
    if (clr != 0) begin
      n_out = 0; n_ovf = 0;
    end else if (load != 0) begin
      n_out = (lv > mx) ? mx : lv;
    end else if (en != 0) begin
      if (out < mx) n_out = out + 1;
      else begin
        n_ovf = 1;
        if (sat == 0) begin n_out = 0; n_wrap = 1; end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int combined;
    int wrap_pulses;
    int n_out, n_wrap, n_ovf;
    logic [3:0] en_r, clr_r, load_r;
    logic [3:0] lv_r[3];

    set0(0, 0, 0, 0); set9(0, 0, 0, 0); sets(0, 0, 0, 0);
    ifc0.en = 0; ifc0.clr = 0; ifc0.load = 0; ifc0.load_val = 0; ifc1.clr = 0;

    // Reset state, then mid-cycle asynchronous reset.
    #2;
    chk("reset_out", int'(if0.out), 0);
    chk("reset_ovf", int'(if0.ovf), 0);
    tick(); tick();
    rst = 1'b1;
    set0(0, 0, 1, 15); tick();
    chk("rst_seq_load15", int'(if0.out), 15);
    set0(1, 0, 0, 0); tick();
    chk("rst_seq_wrap", int'(if0.wrap), 1);
    set0(0, 0, 1, 9); tick();
    chk("rst_seq_out9", int'(if0.out), 9);
    chk("rst_seq_ovf_kept", int'(if0.ovf), 1);
    set0(1, 0, 0, 0);
    #3 rst = 1'b0;
    #1;
    chk("async_rst_out", int'(if0.out), 0);
    chk("async_rst_wrap", int'(if0.wrap), 0);
    chk("async_rst_ovf", int'(if0.ovf), 0);
    tick();
    chk("rst_held_out", int'(if0.out), 0);
    rst = 1'b1;
    tick();
    chk("rst_release_out", int'(if0.out), 1);

    // Vector table on the default instance.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 4'd14, 14, 0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 4'd0,  15, 0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0,  0, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'd0,  1, 0, 1};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'd5,  5, 0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 4'd0,  5, 0, 1};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 4'd7,  0, 0, 0};
    tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'd7,  7, 0, 0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 4'd0,  7, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 4'd15, 15, 0, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 4'd0,  0, 1, 1};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 4'd0,  0, 0, 0};
    for (int i = 0; i < 14; i++) begin
      set0(tbl[i].en, tbl[i].clr, tbl[i].load, tbl[i].lv);
      tick();
      chk($sformatf("vec%0d_out", i), int'(if0.out), tbl[i].e_out);
      chk($sformatf("vec%0d_wrap", i), int'(if0.wrap), tbl[i].e_wrap);
      chk($sformatf("vec%0d_ovf", i), int'(if0.ovf), tbl[i].e_ovf);
    end

    // Wrap sequence: 17 edges from 0, tc only while out=15.
    set0(1, 0, 0, 0);
    for (int k = 1; k <= 17; k++) begin
      #1;
      chk($sformatf("wrapseq_tc%0d", k), int'(if0.tc), (((k - 1) % 16) == 15) ? 1 : 0);
      tick();
      chk($sformatf("wrapseq_out%0d", k), int'(if0.out), k % 16);
      chk($sformatf("wrapseq_wrap%0d", k), int'(if0.wrap), (k == 16) ? 1 : 0);
      chk($sformatf("wrapseq_ovf%0d", k), int'(if0.ovf), (k >= 16) ? 1 : 0);
    end

    // Load clamp with MAX_COUNT=9.
    set9(0, 1, 0, 0); tick();
    set9(0, 0, 1, 12); tick();
    chk("clamp_out", int'(if9.out), 9);
    set9(1, 0, 0, 0); tick();
    chk("clamp_wrap_out", int'(if9.out), 0);
    chk("clamp_wrap_pulse", int'(if9.wrap), 1);
    set9(0, 0, 1, 3); tick();
    chk("clamp_reload_out", int'(if9.out), 3);
    chk("clamp_reload_ovf", int'(if9.ovf), 1);

    // Saturate: 20 edges from 0.
    sets(0, 1, 0, 0); tick();
    sets(1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("sat_out%0d", k), int'(ifs.out), (k < 15) ? k : 15);
      chk($sformatf("sat_wrap%0d", k), int'(ifs.wrap), 0);
      chk($sformatf("sat_ovf%0d", k), int'(ifs.ovf), (k >= 16) ? 1 : 0);
    end

    // Cascade of two 4-bit stages behaves as a mod-256 counter.
    ifc0.clr = 1; ifc1.clr = 1; tick();
    ifc0.clr = 0; ifc1.clr = 0;
    combined = {int'(ifc1.out) << 4} | int'(ifc0.out);
    chk("cascade_start", combined, 0);
    ifc0.en = 1;
    wrap_pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      combined = (int'(ifc1.out) << 4) | int'(ifc0.out);
      chk($sformatf("cascade_%0d", k), combined, k % 256);
      wrap_pulses += int'(ifc1.wrap);
    end
    ifc0.en = 0;
    chk("cascade_stage1_wraps", wrap_pulses, 1);

    // Randomized traffic on three configurations against the model.
    set0(0, 1, 0, 0); set9(0, 1, 0, 0); sets(0, 1, 0, 0); tick();
    for (int j = 0; j < 3; j++) begin m_out[j] = 0; m_ovf[j] = 0; end
    for (int c = 0; c < 300; c++) begin
      for (int j = 0; j < 3; j++) begin
        en_r[j]   = ($urandom_range(0, 3) != 0);
        clr_r[j]  = ($urandom_range(0, 24) == 0);
        load_r[j] = ($urandom_range(0, 9) == 0);
        lv_r[j]   = 4'($urandom_range(0, 15));
      end
      set0(en_r[0], clr_r[0], load_r[0], lv_r[0]);
      set9(en_r[1], clr_r[1], load_r[1], lv_r[1]);
      sets(en_r[2], clr_r[2], load_r[2], lv_r[2]);
      #1;
      chk("rand_tc0", int'(if0.tc), (m_out[0] == maxv[0] && en_r[0]) ? 1 : 0);
      chk("rand_tc9", int'(if9.tc), (m_out[1] == maxv[1] && en_r[1]) ? 1 : 0);
      chk("rand_tcs", int'(ifs.tc), (m_out[2] == maxv[2] && en_r[2]) ? 1 : 0);
      tick();
      for (int j = 0; j < 3; j++) begin
        model_step(m_out[j], m_ovf[j], int'(en_r[j]), int'(clr_r[j]), int'(load_r[j]),
                   int'(lv_r[j]), maxv[j], satv[j], n_out, n_wrap, n_ovf);
        m_out[j] = n_out;
        m_ovf[j] = n_ovf;
        if (j == 0) begin
          chk("rand0_out", int'(if0.out), n_out);
          chk("rand0_wrap", int'(if0.wrap), n_wrap);
          chk("rand0_ovf", int'(if0.ovf), n_ovf);
        end else if (j == 1) begin
          chk("rand9_out", int'(if9.out), n_out);
          chk("rand9_wrap", int'(if9.wrap), n_wrap);
          chk("rand9_ovf", int'(if9.ovf), n_ovf);
        end else begin
          chk("rands_out", int'(ifs.out), n_out);
          chk("rands_wrap", int'(ifs.wrap), n_wrap);
          chk("rands_ovf", int'(ifs.ovf), n_ovf);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_up_counter.md
Name: sync_up_counter

Overview:
- Synchronous binary up-counter; the counting-direction complement to the team's synchronous down-counter.
- Used as an event/tick counter and as a cascadable prescaler stage: terminal-count output feeds the next stage's enable.
- Adds enable, synchronous clear/load, selectable wrap or saturate, and a sticky overflow flag.
- State is held in per-bit D flip-flop slices; next-state is toggle logic (bit i toggles when all lower bits are 1 and counting is enabled).

Parameters:
- WIDTH, 4, counter width in bits (2..16).
- MAX_COUNT, 15, terminal value (1..2^WIDTH-1); count runs 0..MAX_COUNT.
- SATURATE, 0, 0 = wrap to 0 after MAX_COUNT; 1 = hold at MAX_COUNT.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset; 0 = reset asserted.
- en  input  1  count enable; increment on the rising clk edge when 1.
- clr  input  1  synchronous clear to 0; highest synchronous priority.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- out  output  WIDTH  registered count.
- tc  output  1  combinational terminal count: (out == MAX_COUNT) & en.
- wrap  output  1  registered one-cycle pulse; high in the cycle out returns to 0 by wrapping.
- ovf  output  1  registered sticky overflow flag.

Behaviour:
- Reset: rst=0 forces out=0, wrap=0, ovf=0 immediately, with no clock edge needed. Held while rst=0. Counting resumes on the first rising edge after rst returns to 1.
- Per rising edge, priority is clr > load > en > hold:
  - clr=1: out<=0, wrap<=0, ovf<=0. load and en are ignored.
  - load=1: out<=min(load_val, MAX_COUNT), wrap<=0, ovf unchanged. en is ignored.
  - en=1 and out<MAX_COUNT: out<=out+1, wrap<=0.
  - en=1, out==MAX_COUNT, SATURATE=0: out<=0, wrap<=1, ovf<=1.
  - en=1, out==MAX_COUNT, SATURATE=1: out holds, wrap<=0, ovf<=1.
  - en=0: out holds, wrap<=0.
- Latency: one cycle from en to the out change. tc has zero latency, since it is combinational from out and en. wrap appears in the same cycle that out becomes 0.
- wrap is never high for two consecutive cycles unless MAX_COUNT=... (impossible; the minimum MAX_COUNT is 1, so the period is at least 2).
- ovf stays 1 until clr or reset. load does not clear it.
- Arithmetic is unsigned modulo MAX_COUNT+1. When MAX_COUNT < 2^WIDTH-1, values above MAX_COUNT are never reachable, because load clamps.
- Cascading: stage N+1 en = stage N tc. With no clr/load, the chained value equals a single counter of product modulus.
- Reset asserted between edges: outputs go to 0 within the same cycle. Any pending increment is discarded.

Decomposition:
- Shared package (counter_pkg):
  - COUNT_MODE_WRAP=0 and COUNT_MODE_SAT=1 constants for SATURATE.
  - Default WIDTH=4.
  - Helper constant for the all-ones terminal value.
- One sub-module, up_count_bit: a single bit slice.
  - DFF with async active-low reset and next-state mux (clr/load/toggle).
  - Inputs: clk, rst, toggle_in (AND of en and all lower bits), clr, load, load_bit.
  - Output: q.
  - The top instantiates WIDTH slices plus terminal-detect, clamp, wrap and ovf logic.

Test Plan:
- Reset:
  - Drive rst=0 mid-cycle while out=9 → out=0, wrap=0, ovf=0 before the next edge.
  - Release rst, en=1 → out=1 after the first edge.
- Wrap (defaults):
  - en=1 for 17 edges from 0 → out sequence 1..15, 0, 1.
  - tc=1 only while out=15.
  - wrap=1 exactly the one cycle out=0 after 15; ovf=1 thereafter.
- Load and clamp:
  - MAX_COUNT=9: load=1, load_val=12 → out=9.
  - Then en=1 → out=0, wrap=1.
  - Then load_val=3 → out=3, ovf still 1.
- Saturate:
  - SATURATE=1, en=1 for 20 edges → out sticks at 15 from edge 15.
  - wrap never 1; ovf=1 from edge 16.
- Priority:
  - out=5, clr=1, load=1 (load_val=7), en=1 on the same edge → out=0, ovf=0.
  - Next edge, load=1, en=1 → out=7.
- Cascade:
  - Two 4-bit instances, stage1 en = stage0 tc, en=1 for 256 edges → combined {stage1, stage0} counts 0..255, then 0.
  - stage1 wrap pulses once.
